// File: rtl/spi_dac_fifo_tx.sv
// Sample FIFO feeding a mode-0 SPI master for a DAC: one DATA_W-bit word per
// chip-select frame, MSB first, with a guaranteed cs_n high gap between frames.
module spi_dac_fifo_tx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYC    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          push,
    input  logic [DATA_W-1:0]             din,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          cs_n,
    output logic                          sclk,
    output logic                          mosi,
    output logic                          busy,
    output logic                          done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC - 1) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC >= 2) ? GAP_CYC - 2 : 0);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, STOP, GAP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              full_reg, empty_reg, overflow_reg;
    logic              pop, push_ok;

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic              cs_n_reg, sclk_reg, mosi_reg, busy_reg, done_reg;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is kept then.
    always_comb begin
        pop        = (state_reg == IDLE) && en && !empty_reg;
        push_ok    = push && (!full_reg || pop);
        count_next = count_reg;
        if (push_ok && !pop)
            count_next = count_reg + CNT_W'(1);
        else if (pop && !push_ok)
            count_next = count_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg    <= count_next;
            full_reg     <= (count_next == DEPTH);
            empty_reg    <= (count_next == '0);
            overflow_reg <= push && full_reg && !pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            div_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            cs_n_reg    <= 1'b1;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        shift_reg   <= mem[rd_ptr_reg];
                        mosi_reg    <= mem[rd_ptr_reg][DATA_W-1];
                        cs_n_reg    <= 1'b0;
                        busy_reg    <= 1'b1;
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= '0;
                        sclk_reg    <= 1'b1;
                        state_reg   <= SHIFT_HI;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= '0;
                        sclk_reg    <= 1'b0;
                        state_reg   <= SHIFT_LO;
                        // Falling edge advances mosi, except after the final bit.
                        if (bit_cnt_reg != BIT_LAST) begin
                            shift_reg <= {shift_reg[DATA_W-2:0], shift_reg[DATA_W-1]};
                            mosi_reg  <= shift_reg[DATA_W-2];
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            cs_n_reg  <= 1'b1;
                            mosi_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            sclk_reg    <= 1'b1;
                            state_reg   <= SHIFT_HI;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                STOP: begin
                    gap_cnt_reg <= '0;
                    if (GAP_CYC > 1) begin
                        state_reg <= GAP;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign cs_n     = cs_n_reg;
    assign sclk     = sclk_reg;
    assign mosi     = mosi_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
endmodule

// File: doc/spi_dac_fifo_tx.md
Name: spi_dac_fifo_tx

Overview:
- Transmit-side counterpart of the ADC capture path: buffers 8-bit samples pushed by the datapath and serialises each one to an SPI DAC.
- Contains an internal synchronous FIFO and an SPI master (mode 0, MSB first, one word per chip-select frame).
- Sits between the sample-producing logic and the DAC pins: cs_n, sclk, mosi.

Parameters:
- DATA_W, 8, bits per SPI word and FIFO width.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- CLK_DIV, 2, clk cycles per sclk half-period; at least 1.
- GAP_CYC, 2, minimum clk cycles cs_n stays high between frames; at least 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  allows a new frame to start; a frame already in progress always completes
- push  input  1  write din into FIFO
- din  input  DATA_W  sample to transmit
- full  output  1  FIFO full
- empty  output  1  FIFO empty
- count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  output  1  one-cycle pulse when a push is dropped
- cs_n  output  1  DAC chip select, active low
- sclk  output  1  SPI clock, idles low
- mosi  output  1  serial data, MSB first
- busy  output  1  high while state is not IDLE
- done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (asynchronous, active-low): FIFO pointers and count cleared, so count=0, empty=1, full=0. Outputs cs_n=1, sclk=0, mosi=0, busy=0, done=0, overflow=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately. No done pulse. Buffered data is discarded.
- FIFO: all outputs registered.
  - Push is accepted if full=0, or if an internal pop happens in the same cycle.
  - Push while full with no pop: data dropped, count unchanged, overflow=1 for one cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A word pushed into an empty FIFO is visible (empty=0) the next cycle. It cannot be popped in the cycle it is pushed.
- State machine: IDLE -> SETUP -> SHIFT_HI -> SHIFT_LO -> STOP -> GAP -> IDLE.
  - IDLE: sclk=0, cs_n=1. If en=1 and empty=0: pop the FIFO head into the shift register, then next cycle cs_n=0, mosi=head[DATA_W-1], go to SETUP.
  - SETUP: CLK_DIV cycles with sclk=0 (data setup), then go to SHIFT_HI.
  - SHIFT_HI: sclk=1 for CLK_DIV cycles. The DAC samples mosi on this rising edge.
  - SHIFT_LO: sclk=0 for CLK_DIV cycles. On entry (the falling edge) mosi moves to the next lower bit, except after the last bit, where mosi holds. Return to SHIFT_HI until DATA_W bits are sent, then go to STOP.
  - STOP: one cycle; cs_n goes to 1 and done=1, mosi=0.
  - GAP: cs_n=1 for GAP_CYC-1 further cycles, then IDLE.
- Frame timing: cs_n is low for exactly CLK_DIV*(2*DATA_W+1) cycles. With the defaults that is 34 cycles, containing exactly DATA_W rising edges of sclk.
- Frame spacing: the earliest next cs_n fall is GAP_CYC+1 cycles after cs_n rises (GAP plus the IDLE pop cycle).
- busy=1 from the cycle cs_n falls until the cycle GAP exits; it is 0 in IDLE.
- en deasserted mid-frame has no effect on that frame. It only blocks the next IDLE pop.
- Back-to-back: with the FIFO non-empty and en=1, frames repeat at a period of CLK_DIV*(2*DATA_W+1)+GAP_CYC+1 cycles, in FIFO order.
- Counters are sized from the parameters. No width truncation for any legal parameter set.

Test Plan:
- Reset, push 0xA5, en=1 -> cs_n low 34 cycles; 8 sclk rising edges sample 1,0,1,0,0,1,0,1; done pulses once as cs_n rises; count returns to 0.
- Push 0x3C, 0xFF, 0x01 back-to-back -> three frames in that order, cs_n high exactly GAP_CYC+1=3 cycles between them; empty=1 after the third pop.
- Hold en=0 and push 16 words -> full=1, count=16. A 17th push -> overflow pulse, count stays 16. Raise en -> 16 frames carry the first 16 words unchanged.
- FIFO full, push in the same cycle as an IDLE pop -> push accepted, no overflow, count stays 16.
- Assert rst_n low at the 4th sclk rising edge -> cs_n=1, sclk=0, mosi=0 immediately, no done, empty=1. After release, a new push of 0x81 transmits correctly.
- Drop en during a frame -> that frame completes with done; no further frame starts while en=0 even though empty=0.
